// File: rtl/ef_tmr32_seq_pkg.sv
// Shared definitions for the timer duty-cycle sequencer: state encoding and
// the bit layout of one table entry.
package ef_tmr32_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

  localparam int CMP_W    = 32;
  localparam int CMPX_LSB = 0;
  localparam int CMPY_LSB = CMPX_LSB + CMP_W;
  localparam int RPT_LSB  = CMPY_LSB + CMP_W;

  function automatic int entry_width(input int rptw);
    return RPT_LSB + rptw;
  endfunction

endpackage

// File: rtl/ef_tmr32_seq_tbl.sv
// Sequencer entry table: one synchronous write port and one combinational
// read port, so a same-cycle read sees the contents from before the write.
module ef_tmr32_seq_tbl
  import ef_tmr32_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int EW    = 72
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [EW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [EW-1:0] rd_data
);

  logic [EW-1:0] mem [DEPTH];

  // Table contents survive reset on purpose; software reprograms them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ef_tmr32_seq.sv
// Duty-cycle sequencer in front of the 32-bit timer: steps cmpx/cmpy through
// a table, swapping only on timer period boundaries.
module ef_tmr32_seq
  import ef_tmr32_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int RPTW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_wr,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [31:0]     cfg_cmpx,
  input  logic [31:0]     cfg_cmpy,
  input  logic [RPTW-1:0] cfg_rpt,
  input  logic [AW-1:0]   seq_last,
  input  logic            seq_loop,
  input  logic            start,
  input  logic            stop,
  input  logic            timeout_flag,
  output logic            tmr_en,
  output logic [31:0]     cmpx,
  output logic [31:0]     cmpy,
  output logic            busy,
  output logic [AW-1:0]   idx,
  output logic            done
);

  localparam int EW = entry_width(RPTW);

  seq_state_t      state;
  logic            te_d;
  logic            te_rise;
  logic [RPTW-1:0] rpt_cnt;
  logic [AW-1:0]   nxt_idx;
  logic [EW-1:0]   wr_data;
  logic [EW-1:0]   rd_data;
  logic [31:0]     ld_cmpx;
  logic [31:0]     ld_cmpy;
  logic [RPTW-1:0] ld_rpt;

  assign te_rise = timeout_flag & ~te_d;
  assign wr_data = {cfg_rpt, cfg_cmpy, cfg_cmpx};

  // Outside RUN the only possible load is entry 0 (a fresh start).
  always_comb begin
    nxt_idx = '0;
    if (state == RUN && idx != seq_last) begin
      nxt_idx = idx + AW'(1);
    end
  end

  ef_tmr32_seq_tbl #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .EW    (EW)
  ) u_tbl (
    .clk     (clk),
    .wr_en   (cfg_wr),
    .wr_addr (cfg_addr),
    .wr_data (wr_data),
    .rd_addr (nxt_idx),
    .rd_data (rd_data)
  );

  assign ld_cmpx = rd_data[CMPX_LSB +: CMP_W];
  assign ld_cmpy = rd_data[CMPY_LSB +: CMP_W];
  assign ld_rpt  = rd_data[RPT_LSB +: RPTW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tmr_en  <= 1'b0;
      cmpx    <= '0;
      cmpy    <= '0;
      busy    <= 1'b0;
      idx     <= '0;
      done    <= 1'b0;
      rpt_cnt <= '0;
      te_d    <= 1'b0;
    end else begin
      done <= 1'b0;
      te_d <= timeout_flag;
      case (state)
        IDLE: begin
          tmr_en <= 1'b0;
          if (start && !stop) begin
            state   <= ARM;
            busy    <= 1'b1;
            idx     <= '0;
            cmpx    <= ld_cmpx;
            cmpy    <= ld_cmpy;
            rpt_cnt <= ld_rpt;
          end
        end
        ARM: begin
          // Holding te_d high hides a timeout that was already asserted.
          te_d <= 1'b1;
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state  <= RUN;
            tmr_en <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state  <= IDLE;
            busy   <= 1'b0;
            tmr_en <= 1'b0;
          end else if (te_rise) begin
            if (rpt_cnt != '0) begin
              rpt_cnt <= rpt_cnt - RPTW'(1);
            end else if (idx != seq_last || seq_loop) begin
              idx     <= nxt_idx;
              cmpx    <= ld_cmpx;
              cmpy    <= ld_cmpy;
              rpt_cnt <= ld_rpt;
            end else begin
              state  <= IDLE;
              busy   <= 1'b0;
              tmr_en <= 1'b0;
              done   <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          tmr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ef_tmr32_seq.sv
// Randomised scoreboard bench for ef_tmr32_seq: a behavioural sequencer model
// predicts every cycle's outputs and a negedge monitor compares them.
module tb_ef_tmr32_seq;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int RPTW  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_wr = 1'b0;
  logic [AW-1:0]   cfg_addr = '0;
  logic [31:0]     cfg_cmpx = '0;
  logic [31:0]     cfg_cmpy = '0;
  logic [RPTW-1:0] cfg_rpt = '0;
  logic [AW-1:0]   seq_last = '0;
  logic            seq_loop = 1'b0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic            timeout_flag = 1'b0;
  logic            tmr_en;
  logic [31:0]     cmpx;
  logic [31:0]     cmpy;
  logic            busy;
  logic [AW-1:0]   idx;
  logic            done;

  int compared = 0;
  int mismatched = 0;
  int doneSeen = 0;
  int cyc = 0;

  logic [69:0] expQ [$];

  // Reference model: a playlist position, a count of periods left on the
  // current entry, and a copy of the table.
  bit          mActive = 0;
  bit          mArming = 0;
  bit          mTmr = 0;
  bit          mDone = 0;
  bit          mPrevTo = 0;
  int          mPos = 0;
  int          mLeft = 0;
  logic [31:0] mX = '0;
  logic [31:0] mY = '0;
  logic [31:0] tX [DEPTH];
  logic [31:0] tY [DEPTH];
  int          tR [DEPTH];

  ef_tmr32_seq #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .RPTW  (RPTW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_wr       (cfg_wr),
    .cfg_addr     (cfg_addr),
    .cfg_cmpx     (cfg_cmpx),
    .cfg_cmpy     (cfg_cmpy),
    .cfg_rpt      (cfg_rpt),
    .seq_last     (seq_last),
    .seq_loop     (seq_loop),
    .start        (start),
    .stop         (stop),
    .timeout_flag (timeout_flag),
    .tmr_en       (tmr_en),
    .cmpx         (cmpx),
    .cmpy         (cmpy),
    .busy         (busy),
    .idx          (idx),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [69:0] act, input logic [69:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void loadEntry(input int p);
    mX = tX[p];
    mY = tY[p];
    mLeft = tR[p];
  endfunction

  // Predict the outputs after the coming clock edge from the driven inputs.
  function automatic void runModel();
    bit periodEnded;
    bit nextPrev;
    if (rst) begin
      mActive = 0; mArming = 0; mTmr = 0; mDone = 0; mPrevTo = 0;
      mPos = 0; mLeft = 0; mX = '0; mY = '0;
    end else begin
      periodEnded = timeout_flag && !mPrevTo;
      nextPrev = timeout_flag;
      mDone = 0;
      if (!mActive) begin
        mTmr = 0;
        if (start && !stop) begin
          mActive = 1; mArming = 1; mPos = 0;
          loadEntry(0);
        end
      end else if (mArming) begin
        nextPrev = 1;
        mArming = 0;
        if (stop) mActive = 0;
        else mTmr = 1;
      end else if (stop) begin
        mActive = 0; mTmr = 0;
      end else if (periodEnded) begin
        if (mLeft > 0) begin
          mLeft--;
        end else if (mPos != int'(seq_last)) begin
          mPos = (mPos + 1) % DEPTH;
          loadEntry(mPos);
        end else if (seq_loop) begin
          mPos = 0;
          loadEntry(0);
        end else begin
          mActive = 0; mTmr = 0; mDone = 1;
        end
      end
      mPrevTo = nextPrev;
    end
    if (cfg_wr) begin
      tX[cfg_addr] = cfg_cmpx;
      tY[cfg_addr] = cfg_cmpy;
      tR[cfg_addr] = int'(cfg_rpt);
    end
    expQ.push_back({mTmr, mActive, mDone, 3'(mPos), mX, mY});
  endfunction

  // start/stop/cfg_wr are pulses on the first cycle; timeout is held for n.
  task automatic applyStimulus(input bit st, input bit sp, input bit to, input int n);
    for (int i = 0; i < n; i++) begin
      start = st && (i == 0);
      stop = sp && (i == 0);
      if (i != 0) cfg_wr = 1'b0;
      timeout_flag = to;
      runModel();
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    stop = 1'b0;
    cfg_wr = 1'b0;
  endtask

  task automatic writeEntry(input int a, input int x, input int y, input int r);
    cfg_wr = 1'b1;
    cfg_addr = AW'(a);
    cfg_cmpx = 32'(x);
    cfg_cmpy = 32'(y);
    cfg_rpt = RPTW'(r);
    applyStimulus(0, 0, 0, 1);
  endtask

  task automatic risePulse(input int hi, input int lo);
    applyStimulus(0, 0, 1, hi);
    applyStimulus(0, 0, 0, lo);
  endtask

  always @(negedge clk) begin
    logic [69:0] e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput($sformatf("cycle %0d outputs", cyc), {tmr_en, busy, done, idx, cmpx, cmpy}, e);
      if (done) doneSeen++;
    end
    cyc++;
  end

  initial begin
    int d0;
    int expIdx [6];
    expIdx = '{1, 1, 0, 1, 1, 0};

    rst = 1'b1;
    applyStimulus(0, 0, 0, 2);
    checkOutput("reset outputs", {tmr_en, busy, done, idx, cmpx, cmpy}, 70'(0));
    rst = 1'b0;

    // One-shot two-entry sequence.
    writeEntry(0, 10, 20, 0);
    writeEntry(1, 30, 40, 1);
    seq_last = 3'd1;
    seq_loop = 1'b0;
    d0 = doneSeen;
    applyStimulus(1, 0, 0, 1);
    checkOutput("arm tmr_en low", 70'(tmr_en), 70'(0));
    checkOutput("arm cmpx", 70'(cmpx), 70'(10));
    applyStimulus(0, 0, 0, 2);
    checkOutput("run tmr_en high", 70'(tmr_en), 70'(1));
    risePulse(1, 3);
    checkOutput("rise1 cmpx/cmpy", 70'({cmpx, cmpy}), 70'({32'd30, 32'd40}));
    risePulse(1, 3);
    risePulse(1, 3);
    checkOutput("oneshot end tmr_en/busy", 70'({tmr_en, busy}), 70'(0));
    checkOutput("oneshot cmpx held", 70'(cmpx), 70'(30));
    checkOutput("oneshot done count", 70'(doneSeen - d0), 70'(1));

    // Looping sequence.
    seq_loop = 1'b1;
    d0 = doneSeen;
    applyStimulus(1, 0, 0, 3);
    for (int i = 0; i < 6; i++) begin
      risePulse(1, 2);
      checkOutput($sformatf("loop idx step %0d", i), 70'(idx), 70'(expIdx[i]));
    end
    checkOutput("loop no done", 70'(doneSeen - d0), 70'(0));

    // Stop at idx 1, then restart.
    risePulse(1, 2);
    applyStimulus(0, 1, 0, 1);
    checkOutput("stop tmr_en/busy/done", 70'({tmr_en, busy, done}), 70'(0));
    applyStimulus(1, 0, 0, 1);
    checkOutput("restart cmpx", 70'(cmpx), 70'(10));
    applyStimulus(0, 0, 0, 2);

    // Prescaled timeout: one advance per high pulse.
    writeEntry(1, 30, 40, 0);
    risePulse(5, 3);
    checkOutput("presc idx 1", 70'(idx), 70'(1));
    risePulse(5, 3);
    checkOutput("presc idx 0", 70'(idx), 70'(0));
    risePulse(5, 3);
    checkOutput("presc idx 1 again", 70'(idx), 70'(1));

    // Write entry 0 on the same edge as the wrap to entry 0.
    cfg_wr = 1'b1;
    cfg_addr = 3'd0;
    cfg_cmpx = 32'd99;
    cfg_cmpy = 32'd20;
    cfg_rpt = 8'd0;
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 3);
    checkOutput("wrap uses old entry", 70'(cmpx), 70'(10));
    risePulse(1, 2);
    risePulse(1, 2);
    checkOutput("next wrap uses new entry", 70'(cmpx), 70'(99));

    // start+stop together in IDLE, then reset during RUN.
    applyStimulus(0, 1, 0, 1);
    applyStimulus(1, 1, 0, 2);
    checkOutput("start+stop stays idle", 70'(busy), 70'(0));
    applyStimulus(1, 0, 0, 3);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 1);
    checkOutput("reset in run", {tmr_en, busy, done, idx, cmpx, cmpy}, 70'(0));
    rst = 1'b0;

    // Randomised phase over a fully written table.
    for (int a = 0; a < DEPTH; a++) begin
      writeEntry(a, int'($urandom), int'($urandom), int'($urandom_range(0, 2)));
    end
    for (int k = 0; k < 300; k++) begin
      rst = ($urandom_range(0, 99) < 2);
      cfg_wr = ($urandom_range(0, 9) == 0);
      cfg_addr = AW'($urandom_range(0, DEPTH - 1));
      cfg_cmpx = $urandom;
      cfg_cmpy = $urandom;
      cfg_rpt = RPTW'($urandom_range(0, 2));
      if ($urandom_range(0, 19) == 0) seq_last = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 19) == 0) seq_loop = ~seq_loop;
      applyStimulus($urandom_range(0, 9) < 2, $urandom_range(0, 29) == 0, 1,
                    int'($urandom_range(1, 4)));
      rst = 1'b0;
      applyStimulus($urandom_range(0, 19) == 0, 1'b0, 0, int'($urandom_range(1, 5)));
    end

    for (int w = 0; w < 10 && expQ.size() > 0; w++) @(posedge clk);
    if (expQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard drain: actual=%0d pending required=0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
